// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: group G/P type,
// group-count helpers and the parameter legality check used at elaboration.
package cla_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int NBLK_F(input int width, input int block);
        return width / block;
    endfunction

    function automatic int GPS_F(input int width, input int block, input int stages);
        return (width / block) / stages;
    endfunction

    function automatic bit cfg_ok(input int width, input int block, input int stages);
        if (block < 1 || stages < 1 || width < block) return 1'b0;
        if ((width % block) != 0) return 1'b0;
        return (NBLK_F(width, block) % stages) == 0;
    endfunction

endpackage

// File: rtl/cla_group.sv
// One BLOCK-bit lookahead group: local sum from a given carry-in, plus the
// group generate/propagate pair consumed by the stage-level lookahead.
module cla_group
    import cla_pkg::*;
#(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             ci,
    output logic [BLOCK-1:0] sum,
    output gp_t              gp
);

    logic [BLOCK-1:0] g_bit;
    logic [BLOCK-1:0] p_bit;
    logic             grp_g;

    assign g_bit = a & b;
    assign p_bit = a ^ b;

    // G/P must not depend on ci, otherwise the stage lookahead forms a loop
    always_comb begin : group_gp
        grp_g = 1'b0;
        for (int i = 0; i < BLOCK; i++) begin
            grp_g = g_bit[i] | (p_bit[i] & grp_g);
        end
    end

    assign gp = '{g: grp_g, p: &p_bit};

    always_comb begin : group_sum
        logic c;
        c   = ci;
        sum = '0;
        for (int i = 0; i < BLOCK; i++) begin
            sum[i] = p_bit[i] ^ c;
            c      = g_bit[i] | (p_bit[i] & c);
        end
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder with valid/ready on both sides and a global stall.
// Define CLA_PIPE_APPROX_LSB_EN to replace the APPROX_BITS LSBs with a|b (cin ignored).
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int BLOCK       = 4,
    parameter int STAGES      = 2,
    parameter int APPROX_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NBLK = NBLK_F(WIDTH, BLOCK);
    localparam int GPS  = GPS_F(WIDTH, BLOCK, STAGES);
    localparam int SW   = GPS * BLOCK;

    if (!cfg_ok(WIDTH, BLOCK, STAGES) || NBLK < STAGES) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a multiple of BLOCK and WIDTH/BLOCK a multiple of STAGES");
    end
    if (APPROX_BITS < 0 || APPROX_BITS > WIDTH) begin : g_bad_approx
        $error("cla_pipe_adder: APPROX_BITS must lie in 0..WIDTH");
    end

    logic             adv;
    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] b_op;
    logic             cin_op;

`ifdef CLA_PIPE_APPROX_LSB_EN
    localparam logic [WIDTH:0]   AMASK_W = ((WIDTH + 1)'(1) << APPROX_BITS) - (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] AMASK   = AMASK_W[WIDTH-1:0];

    // a|b on the low bits with b zeroed there: the adder reproduces a|b and never carries out of them
    assign a_op   = a | (b & AMASK);
    assign b_op   = b & ~AMASK;
    assign cin_op = cin & 1'b0;
`else
    assign a_op   = a;
    assign b_op   = b;
    assign cin_op = cin;
`endif

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO   = s * SW;
        localparam int SUMW = LO + SW;
        localparam int SRCW = WIDTH - LO;
        localparam int REMW = WIDTH - SUMW;

        logic [SRCW-1:0] src_a;
        logic [SRCW-1:0] src_b;
        logic            c_in;
        logic            v_in;
        logic [SW-1:0]   s_new;
        logic [SUMW-1:0] sum_cat;
        logic [GPS-1:0]  g_v;
        logic [GPS-1:0]  p_v;
        logic [GPS:0]    cv;
        logic [SUMW-1:0] sum_d;
        logic [SUMW-1:0] sum_q;
        logic            c_d;
        logic            c_q;
        logic            vld_d;
        logic            vld_q;

        if (s == 0) begin : g_src
            assign src_a   = a_op;
            assign src_b   = b_op;
            assign c_in    = cin_op;
            assign v_in    = in_valid;
            assign sum_cat = s_new;
        end else begin : g_src
            assign src_a   = g_stage[s-1].g_rem.rem_a_q;
            assign src_b   = g_stage[s-1].g_rem.rem_b_q;
            assign c_in    = g_stage[s-1].c_q;
            assign v_in    = g_stage[s-1].vld_q;
            assign sum_cat = {s_new, g_stage[s-1].sum_q};
        end

        for (genvar j = 0; j < GPS; j++) begin : g_grp
            gp_t gp;

            cla_group #(.BLOCK(BLOCK)) u_grp (
                .a   (src_a[j*BLOCK +: BLOCK]),
                .b   (src_b[j*BLOCK +: BLOCK]),
                .ci  (cv[j]),
                .sum (s_new[j*BLOCK +: BLOCK]),
                .gp  (gp)
            );

            assign g_v[j] = gp.g;
            assign p_v[j] = gp.p;
        end

        // Flat lookahead: carry j is c_in propagated through groups 0..j-1, or a generate from any group below j
        always_comb begin : lookahead
            logic term;
            term = 1'b0;
            cv   = '0;
            for (int j = 0; j <= GPS; j++) begin
                term = c_in;
                for (int m = 0; m < j; m++) term = term & p_v[m];
                cv[j] = term;
                for (int k = 0; k < j; k++) begin
                    term = g_v[k];
                    for (int m = k + 1; m < j; m++) term = term & p_v[m];
                    cv[j] = cv[j] | term;
                end
            end
        end

        always_comb begin : stage_next
            vld_d = vld_q;
            c_d   = c_q;
            sum_d = sum_q;
            if (adv) begin
                vld_d = v_in;
                c_d   = cv[GPS];
                sum_d = sum_cat;
            end
        end

        // ---- stage s register boundary ----
        always_ff @(posedge clk) begin : stage_regs
            if (rst) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else begin
                vld_q <= vld_d;
                c_q   <= c_d;
                sum_q <= sum_d;
            end
        end

        if (REMW > 0) begin : g_rem
            logic [REMW-1:0] rem_a_d;
            logic [REMW-1:0] rem_a_q;
            logic [REMW-1:0] rem_b_d;
            logic [REMW-1:0] rem_b_q;

            always_comb begin : rem_next
                rem_a_d = rem_a_q;
                rem_b_d = rem_b_q;
                if (adv) begin
                    rem_a_d = src_a[SRCW-1:SW];
                    rem_b_d = src_b[SRCW-1:SW];
                end
            end

            // Pending operand bits carry no state of their own, so they skip reset
            always_ff @(posedge clk) begin : rem_regs
                rem_a_q <= rem_a_d;
                rem_b_q <= rem_b_d;
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

endmodule
